// File: rtl/put_ins.sv
// -----------------------------------------------------------------------------
// put_ins -- frame builder that pushes either an instruction frame or a data
// frame into a downstream stream FIFO.
//
// An instruction frame is two header words followed by the 15 instruction
// registers in ascending order.
// A data frame is two header words followed by data_len payload words taken
// from an upstream FIFO.
// The downstream push is combinational, so a non-full downstream FIFO sees
// one word per cycle with no bubbles.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   ins_wr_en/addr/data          instruction register write (IDLE only, slots 0..14)
//   start_inst, start_data       one-cycle frame requests (IDLE only, INST wins)
//   data_len                     payload word count, sampled when a data frame is accepted
//   src_data, src_empty_n        upstream FIFO word / not-empty flag
//   src_read                     upstream FIFO pop
//   fifo_data_dout               downstream stream word
//   fifo_strb_dout               downstream byte strobes
//   fifo_last_dout               downstream last-word flag
//   fifo_user_dout               downstream sideband (always 0)
//   fifo_full_n_din              downstream FIFO can accept
//   fifo_write_dout              downstream FIFO push
//   busy, done                   frame in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module put_ins #(
  parameter int TBITS      = 64,
  parameter int TBYTE      = 8,
  parameter int INSTR_FNUM = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_wr_en,
  input  logic [3:0]        ins_wr_addr,
  input  logic [63:0]       ins_wr_data,
  input  logic              start_inst,
  input  logic              start_data,
  input  logic [15:0]       data_len,
  input  logic [TBITS-1:0]  src_data,
  input  logic              src_empty_n,
  output logic              src_read,
  output logic [TBITS-1:0]  fifo_data_dout,
  output logic [TBYTE-1:0]  fifo_strb_dout,
  output logic              fifo_last_dout,
  output logic              fifo_user_dout,
  input  logic              fifo_full_n_din,
  output logic              fifo_write_dout,
  output logic              busy,
  output logic              done
);

  localparam logic [63:0] HDR_INST = 64'hefef123abbeeff22;
  localparam logic [63:0] HDR_DATA = 64'hefef6543dadaff11;
  localparam logic [3:0]  LAST_SLOT = 4'(INSTR_FNUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    HD0,
    HD1,
    INST,
    DATA,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              is_inst_reg;
  logic [15:0]       len_reg;
  logic [3:0]        wcnt_reg;
  logic [15:0]       dcnt_reg;
  logic [TBITS-1:0]  hold_reg;
  logic [63:0]       ins_mem [0:INSTR_FNUM-1];

  logic              write_next;
  logic              last_next;
  logic [TBITS-1:0]  data_next;
  logic [TBITS-1:0]  header;
  logic              ins_we;

  assign header = is_inst_reg ? TBITS'(HDR_INST) : TBITS'(HDR_DATA);
  assign ins_we = (state_reg == IDLE) && ins_wr_en && (ins_wr_addr <= LAST_SLOT);

  // Instruction registers; only writable between frames so a frame in
  // flight always sends a consistent set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INSTR_FNUM; i++) begin
      if (reset) begin
        ins_mem[i] <= '0;
      end else if (ins_we && (ins_wr_addr == 4'(i))) begin
        ins_mem[i] <= ins_wr_data;
      end
    end
  end

  // Next state and combinational push/data/last.
  always_comb begin
    state_next = state_reg;
    write_next = 1'b0;
    last_next  = 1'b0;
    data_next  = '0;
    case (state_reg)
      IDLE: begin
        if (start_inst || start_data) begin
          state_next = HD0;
        end
      end
      HD0: begin
        write_next = fifo_full_n_din;
        data_next  = header;
        if (write_next) begin
          state_next = HD1;
        end
      end
      HD1: begin
        write_next = fifo_full_n_din;
        data_next  = header;
        if (write_next) begin
          if (is_inst_reg) begin
            state_next = INST;
          end else if (len_reg == 16'd0) begin
            // Empty data frame: the second header word closes the frame.
            state_next = DONE;
            last_next  = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      INST: begin
        write_next = fifo_full_n_din;
        data_next  = TBITS'(ins_mem[wcnt_reg]);
        if (write_next && (wcnt_reg == LAST_SLOT)) begin
          state_next = DONE;
          last_next  = 1'b1;
        end
      end
      DATA: begin
        write_next = src_empty_n & fifo_full_n_din;
        // While stalled, present the last pushed word so the output does
        // not wander with an empty upstream FIFO.
        data_next  = write_next ? src_data : hold_reg;
        if (write_next && (16'(dcnt_reg + 16'd1) == len_reg)) begin
          state_next = DONE;
          last_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      is_inst_reg <= 1'b0;
      len_reg     <= '0;
      wcnt_reg    <= '0;
      dcnt_reg    <= '0;
      hold_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (write_next) begin
        hold_reg <= data_next;
      end
      case (state_reg)
        IDLE: begin
          wcnt_reg <= '0;
          dcnt_reg <= '0;
          if (start_inst) begin
            is_inst_reg <= 1'b1;
          end else if (start_data) begin
            is_inst_reg <= 1'b0;
            len_reg     <= data_len;
          end
        end
        INST: begin
          if (write_next) begin
            wcnt_reg <= wcnt_reg + 4'd1;
          end
        end
        DATA: begin
          if (write_next) begin
            dcnt_reg <= dcnt_reg + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_write_dout = write_next;
  assign fifo_data_dout  = data_next;
  assign fifo_last_dout  = last_next;
  assign fifo_strb_dout  = write_next ? {TBYTE{1'b1}} : {TBYTE{1'b0}};
  assign fifo_user_dout  = 1'b0;
  assign src_read        = (state_reg == DATA) && write_next;
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);

endmodule

// File: tb/tb_put_ins.sv
// -----------------------------------------------------------------------------
// tb_put_ins -- scoreboard bench for put_ins.
// Stimulus tasks push the expected frame (header words, then instruction or
// payload words, last flag on the closing word) into a queue; a monitor on the
// falling edge pops and compares every downstream push.
// -----------------------------------------------------------------------------
module tb_put_ins;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ins_wr_en = 1'b0;
  logic [3:0]  ins_wr_addr = '0;
  logic [63:0] ins_wr_data = '0;
  logic        start_inst = 1'b0;
  logic        start_data = 1'b0;
  logic [15:0] data_len = '0;
  logic [63:0] src_data = '0;
  logic        src_empty_n = 1'b0;
  logic        src_read;
  logic [63:0] fifo_data_dout;
  logic [7:0]  fifo_strb_dout;
  logic        fifo_last_dout;
  logic        fifo_user_dout;
  logic        fifo_full_n_din = 1'b1;
  logic        fifo_write_dout;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  put_ins dut (
    .clk(clk), .reset(reset),
    .ins_wr_en(ins_wr_en), .ins_wr_addr(ins_wr_addr), .ins_wr_data(ins_wr_data),
    .start_inst(start_inst), .start_data(start_data), .data_len(data_len),
    .src_data(src_data), .src_empty_n(src_empty_n), .src_read(src_read),
    .fifo_data_dout(fifo_data_dout), .fifo_strb_dout(fifo_strb_dout),
    .fifo_last_dout(fifo_last_dout), .fifo_user_dout(fifo_user_dout),
    .fifo_full_n_din(fifo_full_n_din), .fifo_write_dout(fifo_write_dout),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  localparam logic [63:0] HDR_INST = 64'hefef123abbeeff22;
  localparam logic [63:0] HDR_DATA = 64'hefef6543dadaff11;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];
  logic [63:0] ins_model [0:14];

  int checks = 0;
  int errors = 0;
  int fn_mode = 0;     // 0: always ready, 1: toggle, 2: random
  int src_mode = 0;    // 0: data whenever queued, 1: random gaps
  bit starve = 1'b0;
  bit pop_pending = 1'b0;
  int cyc = 0;
  int push_cnt = 0;
  int src_pops = 0;
  int done_cnt = 0;
  bit prev_last = 1'b0;
  int first_push_cyc = -1;
  int last_push_cyc = -1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (fifo_write_dout) begin
        push_cnt++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
        last_push_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push actual=%h required=none", fifo_data_dout);
        end else begin
          e = exp_q.pop_front();
          check_eq("push_data", fifo_data_dout, e.data);
          check_eq("push_last", 64'(fifo_last_dout), 64'(e.last));
        end
        check_eq("push_strb_user", {fifo_strb_dout, fifo_user_dout}, 64'h1fe);
      end else begin
        check_eq("idle_strb_last_user", {fifo_strb_dout, fifo_last_dout, fifo_user_dout}, 64'h0);
      end
      if (src_read) begin
        src_pops++;
        pop_pending = 1'b1;
        check_eq("src_read_with_push", 64'(fifo_write_dout), 64'h1);
      end
      if (starve) check_eq("starve_quiet", {fifo_write_dout, src_read}, 64'h0);
      if (done) begin
        done_cnt++;
        check_eq("done_after_last", 64'(prev_last), 64'h1);
      end
      prev_last = fifo_write_dout && fifo_last_dout;
    end else begin
      prev_last = 1'b0;
    end
  end

  // Upstream FIFO and downstream ready drivers.
  always @(posedge clk) begin
    bit gap;
    #2;
    if (pop_pending) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_pending = 1'b0;
    end
    case (fn_mode)
      0: fifo_full_n_din = 1'b1;
      1: fifo_full_n_din = ~fifo_full_n_din;
      default: fifo_full_n_din = 1'($urandom_range(0, 1));
    endcase
    gap = (src_mode == 1) && ($urandom_range(0, 3) == 0);
    src_empty_n = (src_q.size() > 0) && !starve && !gap;
    src_data = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             {fifo_data_dout != 64'h0, busy, done, fifo_write_dout, src_read, fifo_last_dout},
             64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    for (int i = 0; i < 15; i++) ins_model[i] = '0;
  endtask

  task automatic write_ins(input logic [3:0] addr, input logic [63:0] data, input bit applies);
    ins_wr_en = 1'b1;
    ins_wr_addr = addr;
    ins_wr_data = data;
    tick();
    ins_wr_en = 1'b0;
    if (applies && addr < 4'd15) ins_model[addr] = data;
  endtask

  task automatic expect_inst_frame();
    exp_q.push_back('{HDR_INST, 1'b0});
    exp_q.push_back('{HDR_INST, 1'b0});
    for (int i = 0; i < 15; i++) exp_q.push_back('{ins_model[i], i == 14});
  endtask

  task automatic start_inst_frame();
    expect_inst_frame();
    start_inst = 1'b1;
    tick();
    start_inst = 1'b0;
  endtask

  task automatic start_data_frame(input int len, input logic [63:0] base, input bit rnd);
    logic [63:0] w;
    exp_q.push_back('{HDR_DATA, 1'b0});
    exp_q.push_back('{HDR_DATA, len == 0});
    for (int i = 0; i < len; i++) begin
      w = rnd ? {$urandom, $urandom} : base + 64'(i);
      src_q.push_back(w);
      exp_q.push_back('{w, i == len - 1});
    end
    data_len = 16'(len);
    start_data = 1'b1;
    tick();
    start_data = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check_eq({name, "_done"}, 64'(done_cnt != d0), 64'h1);
    check_eq({name, "_drained"}, 64'(exp_q.size()), 64'h0);
    check_eq({name, "_idle"}, 64'(busy), 64'h0);
    exp_q.delete();
  endtask

  initial begin
    int p0, s0, n;
    logic [63:0] junk;

    // Reset state.
    do_reset();

    // Nominal instruction frame, downstream always ready.
    fn_mode = 0;
    src_mode = 0;
    for (int k = 0; k < 15; k++) write_ins(4'(k), 64'h1000 + 64'(k), 1'b1);
    write_ins(4'd15, 64'hdead, 1'b0);
    first_push_cyc = -1;
    p0 = push_cnt;
    s0 = src_pops;
    start_inst_frame();
    wait_done("inst_nominal", 60);
    check_eq("inst_push_count", 64'(push_cnt - p0), 64'd17);
    check_eq("inst_back_to_back", 64'(last_push_cyc - first_push_cyc), 64'd16);
    check_eq("inst_no_src_read", 64'(src_pops - s0), 64'd0);

    // Data frame with toggling backpressure.
    fn_mode = 1;
    p0 = push_cnt;
    s0 = src_pops;
    start_data_frame(4, 64'hA0, 1'b0);
    wait_done("data_backpressure", 60);
    check_eq("data_bp_pushes", 64'(push_cnt - p0), 64'd6);
    check_eq("data_bp_src_reads", 64'(src_pops - s0), 64'd4);

    // Zero-length data frame.
    fn_mode = 0;
    p0 = push_cnt;
    s0 = src_pops;
    start_data_frame(0, 64'h0, 1'b0);
    wait_done("data_zero", 20);
    check_eq("data_zero_pushes", 64'(push_cnt - p0), 64'd2);
    check_eq("data_zero_src_reads", 64'(src_pops - s0), 64'd0);

    // Simultaneous start: INST wins; starts and writes while busy are ignored.
    p0 = push_cnt;
    expect_inst_frame();
    data_len = 16'd3;
    start_inst = 1'b1;
    start_data = 1'b1;
    tick();
    start_inst = 1'b0;
    start_data = 1'b0;
    tick();
    tick();
    start_data = 1'b1;
    tick();
    start_data = 1'b0;
    write_ins(4'd3, 64'hbad0bad0, 1'b0);
    wait_done("simul_start", 60);
    for (int i = 0; i < 20; i++) tick();
    check_eq("simul_push_count", 64'(push_cnt - p0), 64'd17);
    check_eq("simul_stays_idle", 64'(busy), 64'h0);
    start_inst_frame();
    wait_done("regs_unchanged", 60);

    // Upstream starvation mid-payload.
    p0 = push_cnt;
    s0 = src_pops;
    start_data_frame(8, 64'h5500, 1'b0);
    n = 0;
    while (src_pops - s0 < 3 && n < 50) begin
      tick();
      n++;
    end
    check_eq("starve_reached_mid", 64'(src_pops - s0 >= 3), 64'h1);
    starve = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    starve = 1'b0;
    wait_done("starve", 60);
    check_eq("starve_pushes", 64'(push_cnt - p0), 64'd10);
    check_eq("starve_src_reads", 64'(src_pops - s0), 64'd8);

    // Randomized frames and register updates.
    fn_mode = 2;
    src_mode = 1;
    for (int t = 0; t < 24; t++) begin
      for (int w = 0; w < 3; w++) begin
        junk = {$urandom, $urandom};
        write_ins(4'($urandom_range(0, 15)), junk, 1'b1);
      end
      p0 = push_cnt;
      s0 = src_pops;
      if ($urandom_range(0, 2) == 0) begin
        start_inst_frame();
        wait_done("rand_inst", 200);
        check_eq("rand_inst_pushes", 64'(push_cnt - p0), 64'd17);
      end else begin
        n = $urandom_range(0, 12);
        start_data_frame(n, 64'h0, 1'b1);
        wait_done("rand_data", 300);
        check_eq("rand_data_pushes", 64'(push_cnt - p0), 64'(n + 2));
        check_eq("rand_data_src_reads", 64'(src_pops - s0), 64'(n));
      end
    end

    // Reset in the middle of an instruction frame.
    fn_mode = 0;
    src_mode = 0;
    for (int k = 0; k < 15; k++) write_ins(4'(k), 64'h7700 + 64'(k), 1'b1);
    p0 = push_cnt;
    start_inst_frame();
    n = 0;
    while (push_cnt - p0 < 3 && n < 20) begin
      tick();
      n++;
    end
    check_eq("midreset_reached", 64'(push_cnt - p0 >= 3), 64'h1);
    do_reset();
    p0 = push_cnt;
    start_inst_frame();
    wait_done("after_reset_zero_regs", 60);
    check_eq("after_reset_pushes", 64'(push_cnt - p0), 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
